// File: rtl/lfsr_bist_pkg.sv
// Shared types and helpers for the LFSR-driven RAM BIST: FSM state encoding,
// default Galois feedback mask and the single-step LFSR function.
package lfsr_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_e;

    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

    // Widest LFSR the step helper supports; callers zero-extend and truncate.
    localparam int LFSR_MAX_W = 64;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] x,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return (x >> 1) ^ (x[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR register with synchronous load and step; resets to 1 so the
// sequence never starts in the all-zero lock-up state.
module lfsr_galois
    import lfsr_bist_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q <= WIDTH'(1);
        end else if (load_i) begin
            q <= seed_i;
        end else if (step_i) begin
            q <= WIDTH'(lfsr_step(LFSR_MAX_W'(q), LFSR_MAX_W'(TAPS)));
        end
    end

    assign q_o = q;

endmodule

// File: rtl/lfsr_ram_bist.sv
// RAM BIST controller: writes an LFSR sequence to every address, reseeds and
// reads it back through a 1-deep compare pipe. Option: LFSR_BIST_STOP_ON_FAIL_EN.
module lfsr_ram_bist
    import lfsr_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    RAM_DEPTH  = 1000,
    parameter logic [DATA_WIDTH-1:0] TAPS       = DATA_WIDTH'(DEFAULT_TAPS),
    parameter int                    ERR_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  we_o,
    output logic                  rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_W-1:0]      err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    localparam int               CNT_W    = $clog2(RAM_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RAM_DEPTH - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] seed_fix;
    logic [DATA_WIDTH-1:0] lfsr_q;
    logic [DATA_WIDTH-1:0] lfsr_seed;
    logic                  lfsr_load;
    logic                  lfsr_step_en;
    logic                  pipe_valid_q;
    logic [DATA_WIDTH-1:0] pipe_exp_q;
    logic [ADDR_WIDTH-1:0] pipe_addr_q;
    logic [ERR_W-1:0]      err_cnt_q;
    logic [ADDR_WIDTH-1:0] first_err_q;
    logic                  start_ok;
    logic                  last;
    logic                  mismatch;

    assign start_ok = start_i && (state_q == IDLE || state_q == DONE);
    assign last     = (cnt_q == LAST_CNT);
    assign seed_fix = (seed_i == '0) ? DATA_WIDTH'(1) : seed_i;

    // Unknown read data must fail the test, hence the 4-state comparison.
    assign mismatch = pipe_valid_q && (state_q == READ || state_q == DRAIN) &&
                      (ram_data_i !== pipe_exp_q);

    // The read pass replays the sequence from the latched seed.
    assign lfsr_load    = start_ok || (state_q == WRITE && last);
    assign lfsr_seed    = start_ok ? seed_fix : seed_q;
    assign lfsr_step_en = (state_q == WRITE) || (state_q == READ);

    lfsr_galois #(
        .WIDTH (DATA_WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (lfsr_load),
        .seed_i (lfsr_seed),
        .step_i (lfsr_step_en),
        .q_o    (lfsr_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start_ok) state_d = WRITE;
            WRITE:      if (last)     state_d = READ;
            READ: begin
`ifdef LFSR_BIST_STOP_ON_FAIL_EN
                if (mismatch)  state_d = DONE;
                else if (last) state_d = DRAIN;
`else
                if (last) state_d = DRAIN;
`endif
            end
            DRAIN:      state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        we_o   = 1'b0;
        rd_o   = 1'b0;
        addr_o = '0;
        data_o = '0;
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            WRITE: begin
                we_o   = 1'b1;
                addr_o = ADDR_WIDTH'(cnt_q);
                data_o = lfsr_q;
                busy_o = 1'b1;
            end
            READ: begin
                rd_o   = 1'b1;
                addr_o = ADDR_WIDTH'(cnt_q);
                busy_o = 1'b1;
            end
            DRAIN:   busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
        pass_o = (state_q == DONE) && (err_cnt_q == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            seed_q       <= '0;
            pipe_valid_q <= 1'b0;
            pipe_exp_q   <= '0;
            pipe_addr_q  <= '0;
            err_cnt_q    <= '0;
            first_err_q  <= '0;
        end else begin
            if (start_ok) begin
                seed_q      <= seed_fix;
                err_cnt_q   <= '0;
                first_err_q <= '0;
            end

            if ((state_q == WRITE || state_q == READ) && !last) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end

            pipe_valid_q <= (state_q == READ);
            pipe_exp_q   <= lfsr_q;
            pipe_addr_q  <= ADDR_WIDTH'(cnt_q);

            if (mismatch) begin
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
                if (err_cnt_q == '0) begin
                    first_err_q <= pipe_addr_q;
                end
            end
        end
    end

    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_lfsr_ram_bist.sv
// Scoreboard bench for lfsr_ram_bist on an 8-word behavioural RAM with
// per-address bit0 fault injection; expectations come from a sequence model.
module tb_lfsr_ram_bist;

    localparam int          N    = 8;
    localparam int          AW   = $clog2(N);
    localparam logic [31:0] TAPS = 32'h8020_0003;
`ifdef LFSR_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit pass;
        int err;
        int first;
        int cycles;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] seed_i = '0;
    logic        we_o, rd_o, busy_o, done_o, pass_o;
    logic [31:0] addr_o, data_o, first_err_addr_o;
    logic [31:0] ram_data = '0;
    logic [15:0] err_cnt_o;

    logic [31:0]  mem [N];
    logic [N-1:0] fault_en = '0;

    wr_t  wq [$];
    int   rq [$];
    res_t rsq [$];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    bit done_prev = 1'b0;

    lfsr_ram_bist #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RAM_DEPTH  (N),
        .TAPS       (TAPS),
        .ERR_W      (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .seed_i           (seed_i),
        .we_o             (we_o),
        .rd_o             (rd_o),
        .addr_o           (addr_o),
        .data_o           (data_o),
        .ram_data_i       (ram_data),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .err_cnt_o        (err_cnt_o),
        .first_err_addr_o (first_err_addr_o)
    );

    always #5 clk = ~clk;

    // Registered single-port RAM; a faulted address returns bit0 inverted.
    always @(posedge clk) begin
        if (we_o && addr_o < N) mem[addr_o[AW-1:0]] <= data_o;
        if (rd_o && addr_o < N) ram_data <= mem[addr_o[AW-1:0]] ^ {31'b0, fault_en[addr_o[AW-1:0]]};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: the sequence the RAM should hold and the verdict its faults imply.
    task automatic push_model(input logic [31:0] seed, input logic [N-1:0] faults);
        logic [31:0] x;
        int          nflt, first, nreads;
        res_t        r;
        x = (seed == 0) ? 32'd1 : seed;
        for (int i = 0; i < N; i++) begin
            wq.push_back('{addr: i, data: x});
            x = (x >> 1) ^ (x[0] ? TAPS : 32'h0);
        end
        nflt  = 0;
        first = -1;
        for (int i = 0; i < N; i++) begin
            if (faults[i]) begin
                nflt++;
                if (first < 0) first = i;
            end
        end
        if (STOP && first >= 0) begin
            nreads   = (first + 1 < N) ? first + 2 : N;
            r.err    = 1;
            r.cycles = N + first + 2;
        end else begin
            nreads   = N;
            r.err    = nflt;
            r.cycles = 2 * N + 1;
        end
        r.pass  = (r.err == 0);
        r.first = (first < 0) ? 0 : first;
        for (int i = 0; i < nreads; i++) rq.push_back(i);
        rsq.push_back(r);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * N + 10; i++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {63'b0, seen}, 64'd1);
    endtask

    task automatic pulse_start(input logic [31:0] seed, input logic [N-1:0] faults);
        @(negedge clk);
        seed_i   = seed;
        fault_en = faults;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    task automatic run_test(input logic [31:0] seed, input logic [N-1:0] faults);
        push_model(seed, faults);
        pulse_start(seed, faults);
        wait_done();
        @(negedge clk);
    endtask

    // Monitor: every bus cycle and every completion is popped against the queues.
    always @(negedge clk) begin
        wr_t  e;
        int   ra;
        res_t r;
        if (!rst_i) begin
            check("we_rd_excl", {63'b0, we_o & rd_o}, 64'd0);
            if (we_o) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected addr=%0d expected=none", addr_o);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", addr_o, e.addr);
                    check("wr_data", data_o, e.data);
                end
            end
            if (rd_o) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected addr=%0d expected=none", addr_o);
                end else begin
                    ra = rq.pop_front();
                    check("rd_addr", addr_o, ra);
                end
            end
            if (!we_o && !rd_o) begin
                check("idle_addr", addr_o, 0);
                check("idle_data", data_o, 0);
            end
            if (busy_o) busy_cnt++;
            if (done_o && !done_prev) begin
                if (rsq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected err=%0d expected=none", err_cnt_o);
                end else begin
                    r = rsq.pop_front();
                    check("pass", {63'b0, pass_o}, {63'b0, r.pass});
                    check("err_cnt", err_cnt_o, r.err);
                    check("first_err_addr", first_err_addr_o, r.first);
                    check("busy_cycles", busy_cnt, r.cycles);
                end
                busy_cnt = 0;
            end
        end
        done_prev = done_o;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_we", {63'b0, we_o}, 0);
        check("rst_rd", {63'b0, rd_o}, 0);
        check("rst_busy", {63'b0, busy_o}, 0);
        check("rst_done", {63'b0, done_o}, 0);
        check("rst_pass", {63'b0, pass_o}, 0);
        check("rst_err", err_cnt_o, 0);
        check("rst_first", first_err_addr_o, 0);
        check("rst_addr_data", {addr_o, data_o}, 0);
        rst_i = 1'b0;

        run_test(32'd1, 8'h00);
        run_test(32'd1, 8'h08);
        run_test(32'd0, 8'h00);

        // Abort in WRITE at address 4, then a fresh clean run.
        push_model(32'h1234_5678, 8'h00);
        pulse_start(32'h1234_5678, 8'h00);
        for (int i = 0; i < 4 * N; i++) begin
            if (we_o && addr_o == 4) break;
            @(negedge clk);
        end
        check("abort_at_addr4", {63'b0, we_o && addr_o == 4}, 64'd1);
        #1 rst_i = 1'b1;
        wq.delete();
        rq.delete();
        rsq.delete();
        busy_cnt = 0;
        @(negedge clk);
        check("abort_busy", {63'b0, busy_o}, 0);
        check("abort_done", {63'b0, done_o}, 0);
        check("abort_we_rd", {62'b0, we_o, rd_o}, 0);
        check("abort_err", err_cnt_o, 0);
        check("abort_addr_data", {addr_o, data_o}, 0);
        #1 rst_i = 1'b0;
        run_test(32'h1234_5678, 8'h00);

        // start_i held: ignored while busy, reruns straight out of DONE.
        push_model(32'hdead_beef, 8'h00);
        push_model(32'hdead_beef, 8'h00);
        @(negedge clk);
        seed_i   = 32'hdead_beef;
        fault_en = '0;
        start_i  = 1'b1;
        wait_done();
        @(negedge clk);
        check("rerun_done_drop", {63'b0, done_o}, 0);
        check("rerun_busy", {63'b0, busy_o}, 1);
        wait_done();
        start_i = 1'b0;
        @(negedge clk);

        run_test(32'hcafe_0001, 8'h24);
        run_test(32'h0bad_f00d, 8'h80);

        for (int r = 0; r < 6; r++) begin
            logic [31:0]  s;
            logic [N-1:0] f;
            s = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            f = N'($urandom & $urandom);
            run_test(s, f);
        end

        repeat (2) @(negedge clk);
        check("wq_left", wq.size(), 0);
        check("rq_left", rq.size(), 0);
        check("rsq_left", rsq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
